// File: rtl/cache_pkg.sv
// Shared cache definitions: word/byte-enable widths and a way-index width helper.
// Used by cache_set and the cache controller.
package cache_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int BE_WIDTH   = WORD_WIDTH / 8;

  // Minimum 1 bit so a single-way set still has a legal index port.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/cache_set_repl.sv
// Replacement state for one cache set: tree pseudo-LRU when CACHE_SET_PLRU_EN
// is defined, otherwise a round-robin pointer advanced on valid-victim fills.
module cache_set_repl
  import cache_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int WAY_W = clog2(WAYS)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             touch,
  input  logic [WAY_W-1:0] touch_way,
  input  logic             choose,
  output logic [WAY_W-1:0] victim_way
);

  generate
    if (WAYS == 1) begin : g_one
      logic unused_repl;
      assign unused_repl = ^{clk, nrst, touch, touch_way, choose};
      assign victim_way  = '0;
    end else begin : g_multi
`ifdef CACHE_SET_PLRU_EN
      // Heap-ordered tree: node n has children 2n+1 / 2n+2; bit 0 points left.
      logic [WAYS-2:0] tree, tree_nxt;
      logic            unused_repl;
      assign unused_repl = choose;

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)      tree <= '0;
        else if (touch) tree <= tree_nxt;
      end

      always_comb begin
        int node, tw, d;
        tree_nxt = tree;
        node     = 0;
        tw       = int'(touch_way);
        for (int l = 0; l < WAY_W; l++) begin
          d = (tw >> (WAY_W - 1 - l)) & 1;
          tree_nxt[node[WAY_W-1:0]] = (d == 0);
          node = 2 * node + 1 + d;
        end
      end

      always_comb begin
        int node, v, d;
        node = 0;
        v    = 0;
        for (int l = 0; l < WAY_W; l++) begin
          d    = int'(tree[node[WAY_W-1:0]]);
          v    = (v << 1) | d;
          node = 2 * node + 1 + d;
        end
        victim_way = v[WAY_W-1:0];
      end
`else
      logic [WAY_W-1:0] ptr;
      logic             unused_repl;
      assign unused_repl = ^{touch, touch_way};

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)       ptr <= '0;
        else if (choose) ptr <= ptr + 1'b1;
      end

      assign victim_way = ptr;
`endif
    end
  endgenerate

endmodule

// File: rtl/cache_set.sv
// One cache set: WAYS lines with tag/valid/dirty, parallel lookup, stores,
// sequential refill and victim read-out. CACHE_SET_PLRU_EN selects pseudo-LRU.
module cache_set
  import cache_pkg::*;
#(
  parameter int WAYS         = 4,
  parameter int OFFSET_WIDTH = 4,
  parameter int TAG_WIDTH    = 20
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    lk_req,
  input  logic [TAG_WIDTH-1:0]    lk_tag,
  input  logic [OFFSET_WIDTH-1:0] lk_off,
  output logic                    hit,
  output logic [clog2(WAYS)-1:0]  hit_way,
  output logic [WORD_WIDTH-1:0]   rd_data,
  output logic                    rd_vld,
  input  logic                    st_req,
  input  logic [WORD_WIDTH-1:0]   st_data,
  input  logic [BE_WIDTH-1:0]     st_be,
  input  logic                    fill_start,
  input  logic [TAG_WIDTH-1:0]    fill_tag,
  input  logic                    fill_wr,
  input  logic [WORD_WIDTH-1:0]   fill_data,
  output logic [clog2(WAYS)-1:0]  victim_way,
  output logic [TAG_WIDTH-1:0]    victim_tag,
  output logic                    victim_dirty,
  input  logic [OFFSET_WIDTH-1:0] wb_off,
  output logic [WORD_WIDTH-1:0]   wb_data,
  output logic                    busy,
  output logic                    fill_done,
  input  logic                    inv_all
);

  localparam int WAY_W      = clog2(WAYS);
  localparam int LINE_WORDS = 2 ** OFFSET_WIDTH;

  logic [WORD_WIDTH-1:0]   mem  [WAYS][LINE_WORDS];
  logic [TAG_WIDTH-1:0]    tags [WAYS];
  logic [WAYS-1:0]         valid, dirty;
  logic [OFFSET_WIDTH-1:0] cnt;
  logic [TAG_WIDTH-1:0]    fill_tag_q;
  logic [WAY_W-1:0]        repl_way, pick_way, touch_way;
  logic                    any_invalid, fill_go, wr_go, wr_last, lk_hit, st_hit, touch;

  // The way being refilled (victim_way while busy) never hits.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[w] && tags[w] == lk_tag && !(busy && victim_way == WAY_W'(w))) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    any_invalid = 1'b0;
    pick_way    = repl_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        any_invalid = 1'b1;
        pick_way    = WAY_W'(w);
      end
    end
  end

  assign fill_go   = fill_start && !busy && !inv_all;
  assign wr_go     = fill_wr && busy && !inv_all;
  assign wr_last   = wr_go && (cnt == OFFSET_WIDTH'(LINE_WORDS - 1));
  assign lk_hit    = lk_req && hit;
  assign st_hit    = st_req && hit;
  assign touch     = wr_last || lk_hit || st_hit;
  assign touch_way = wr_last ? victim_way : hit_way;

  cache_set_repl #(.WAYS(WAYS), .WAY_W(WAY_W)) u_repl (
    .clk        (clk),
    .nrst       (nrst),
    .touch      (touch),
    .touch_way  (touch_way),
    .choose     (fill_go && !any_invalid),
    .victim_way (repl_way)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int w = 0; w < WAYS; w++) begin
        tags[w] <= '0;
        for (int i = 0; i < LINE_WORDS; i++) mem[w][i] <= '0;
      end
      valid        <= '0;
      dirty        <= '0;
      cnt          <= '0;
      fill_tag_q   <= '0;
      busy         <= 1'b0;
      fill_done    <= 1'b0;
      victim_way   <= '0;
      victim_tag   <= '0;
      victim_dirty <= 1'b0;
      rd_data      <= '0;
      rd_vld       <= 1'b0;
      wb_data      <= '0;
    end else begin
      rd_vld    <= lk_hit;
      fill_done <= wr_last;
      wb_data   <= mem[victim_way][wb_off];
      if (lk_hit) rd_data <= mem[hit_way][lk_off];
      if (st_hit) begin
        for (int b = 0; b < BE_WIDTH; b++)
          if (st_be[b]) mem[hit_way][lk_off][8*b +: 8] <= st_data[8*b +: 8];
        dirty[hit_way] <= 1'b1;
      end
      if (fill_go) begin
        victim_way        <= pick_way;
        victim_tag        <= tags[pick_way];
        victim_dirty      <= valid[pick_way] && dirty[pick_way];
        valid[pick_way]   <= 1'b0;
        dirty[pick_way]   <= 1'b0;
        fill_tag_q        <= fill_tag;
        cnt               <= '0;
        busy              <= 1'b1;
      end
      if (wr_go) begin
        mem[victim_way][cnt] <= fill_data;
        cnt                  <= cnt + 1'b1;
        if (wr_last) begin
          tags[victim_way]  <= fill_tag_q;
          valid[victim_way] <= 1'b1;
          dirty[victim_way] <= 1'b0;
          busy              <= 1'b0;
        end
      end
      // Last so it overrides a same-cycle store's dirty set.
      if (inv_all) begin
        valid <= '0;
        dirty <= '0;
        busy  <= 1'b0;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cache_set.sv
// Directed bench for cache_set: lookup vector table plus hand-written fill,
// store, eviction, invalidate and reset sequences.
module tb_cache_set;
  import cache_pkg::*;

  logic        clk = 1'b0, nrst = 1'b0;
  logic        lk_req = 0, st_req = 0, fill_start = 0, fill_wr = 0, inv_all = 0;
  logic [19:0] lk_tag = '0, fill_tag = '0;
  logic [3:0]  lk_off = '0, wb_off = '0, st_be = '0;
  logic [31:0] st_data = '0, fill_data = '0;
  logic        hit, rd_vld, victim_dirty, busy, fill_done;
  logic [1:0]  hit_way, victim_way;
  logic [31:0] rd_data, wb_data;
  logic [19:0] victim_tag;

  cache_set dut (
    .clk(clk), .nrst(nrst), .lk_req(lk_req), .lk_tag(lk_tag), .lk_off(lk_off),
    .hit(hit), .hit_way(hit_way), .rd_data(rd_data), .rd_vld(rd_vld),
    .st_req(st_req), .st_data(st_data), .st_be(st_be),
    .fill_start(fill_start), .fill_tag(fill_tag), .fill_wr(fill_wr), .fill_data(fill_data),
    .victim_way(victim_way), .victim_tag(victim_tag), .victim_dirty(victim_dirty),
    .wb_off(wb_off), .wb_data(wb_data), .busy(busy), .fill_done(fill_done),
    .inv_all(inv_all)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] last_rd = '0;

  typedef struct {
    logic [19:0] tag;
    logic [3:0]  off;
    logic        hit;
    logic [1:0]  way;
    logic [31:0] rd;
  } lk_vec_t;

  lk_vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [19:0] tag, input logic [3:0] off, input logic eh,
                        input logic [1:0] ew, input logic [31:0] erd);
    lk_req = 1'b1; lk_tag = tag; lk_off = off;
    #1;
    check("hit", hit, eh);
    if (eh) check("hit_way", hit_way, ew);
    step();
    lk_req = 1'b0;
    check("rd_vld", rd_vld, eh);
    if (eh) last_rd = erd;
    check("rd_data", rd_data, last_rd);
  endtask

  task automatic store(input logic [19:0] tag, input logic [3:0] off,
                       input logic [31:0] d, input logic [3:0] be);
    st_req = 1'b1; lk_tag = tag; lk_off = off; st_data = d; st_be = be;
    step();
    st_req = 1'b0;
  endtask

  task automatic start_fill(input logic [19:0] tag, input logic [1:0] ew,
                            input logic [19:0] evtag, input logic evd);
    fill_start = 1'b1; fill_tag = tag;
    step();
    fill_start = 1'b0;
    check("busy_at_start", busy, 1'b1);
    check("victim_way", victim_way, ew);
    check("victim_tag", victim_tag, evtag);
    check("victim_dirty", victim_dirty, evd);
  endtask

  task automatic fill_words(input int n, input logic [31:0] base, input int first);
    for (int i = 0; i < n; i++) begin
      fill_wr = 1'b1; fill_data = base + 32'(first + i);
      step();
    end
    fill_wr = 1'b0;
  endtask

  task automatic fill_line(input logic [19:0] tag, input logic [31:0] base, input logic [1:0] ew,
                           input logic [19:0] evtag, input logic evd);
    start_fill(tag, ew, evtag, evd);
    fill_words(15, base, 0);
    check("busy_before_last", busy, 1'b1);
    check("fill_done_early", fill_done, 1'b0);
    fill_words(1, base, 15);
    check("busy_after_last", busy, 1'b0);
    check("fill_done_pulse", fill_done, 1'b1);
    step();
    check("fill_done_clear", fill_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  ev;
    logic [19:0] evtag;
    logic        evd;
    logic [31:0] ewb;

    vecs[0] = '{20'hABCDE, 4'd2,  1'b1, 2'd0, 32'h0000BEEF};
    vecs[1] = '{20'hABCDE, 4'd15, 1'b1, 2'd0, 32'h0000010F};
    vecs[2] = '{20'h11111, 4'd0,  1'b1, 2'd1, 32'h00001000};
    vecs[3] = '{20'h33333, 4'd15, 1'b1, 2'd3, 32'h0000300F};
    vecs[4] = '{20'h12345, 4'd1,  1'b0, 2'd0, 32'h0};
    vecs[5] = '{20'h00000, 4'd0,  1'b0, 2'd0, 32'h0};
    vecs[6] = '{20'h22222, 4'd7,  1'b1, 2'd2, 32'h00002007};
    vecs[7] = '{20'hABCDE, 4'd4,  1'b1, 2'd0, 32'hCAFEF00D};
    vecs[8] = '{20'h22222, 4'd1,  1'b1, 2'd2, 32'h00002001};

    // Reset state
    lk_req = 1'b1; lk_tag = 20'h12345; lk_off = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hit", hit, 1'b0);
    check("rst_rd_vld", rd_vld, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_victim_dirty", victim_dirty, 1'b0);
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    step();
    check("miss_rd_vld", rd_vld, 1'b0);
    lk_req = 1'b0;

    // First fill lands in way 0; a stray fill_wr afterwards must be ignored
    fill_line(20'hABCDE, 32'h100, 2'd0, 20'h0, 1'b0);
    fill_wr = 1'b1; fill_data = 32'hBAD;
    step();
    fill_wr = 1'b0;
    check("idle_fill_wr_busy", busy, 1'b0);
    lookup(20'hABCDE, 4'd5, 1'b1, 2'd0, 32'h105);
    lookup(20'hABCDE, 4'd0, 1'b1, 2'd0, 32'h100);

    // Partial-byte store, then same-cycle store + lookup returns the old word
    store(20'hABCDE, 4'd2, 32'hDEADBEEF, 4'b0011);
    lookup(20'hABCDE, 4'd2, 1'b1, 2'd0, 32'h0000BEEF);
    st_req = 1'b1; st_data = 32'hCAFEF00D; st_be = 4'hF;
    lookup(20'hABCDE, 4'd4, 1'b1, 2'd0, 32'h104);
    st_req = 1'b0;

    fill_line(20'h11111, 32'h1000, 2'd1, 20'h0, 1'b0);
    fill_line(20'h22222, 32'h2000, 2'd2, 20'h0, 1'b0);
    fill_line(20'h33333, 32'h3000, 2'd3, 20'h0, 1'b0);

    for (int i = 0; i < 9; i++)
      lookup(vecs[i].tag, vecs[i].off, vecs[i].hit, vecs[i].way, vecs[i].rd);

    // Set full, last touches way 0 then way 2
`ifdef CACHE_SET_PLRU_EN
    ev = 2'd1; evtag = 20'h11111; evd = 1'b0; ewb = 32'h1002;
`else
    ev = 2'd0; evtag = 20'hABCDE; evd = 1'b1; ewb = 32'h0000BEEF;
`endif
    start_fill(20'h44444, ev, evtag, evd);
    wb_off = 4'd2;
    step();
    check("wb_data", wb_data, ewb);
    lookup(evtag, 4'd0, 1'b0, 2'd0, 32'h0);
    lookup(20'h22222, 4'd3, 1'b1, 2'd2, 32'h2003);
    fill_words(3, 32'h4000, 0);

    inv_all = 1'b1;
    step();
    inv_all = 1'b0;
    check("inv_busy", busy, 1'b0);
    check("inv_fill_done", fill_done, 1'b0);
    fill_words(13, 32'h4000, 3);
    check("inv_no_done", fill_done, 1'b0);
    lookup(20'h22222, 4'd0, 1'b0, 2'd0, 32'h0);
    lookup(20'h33333, 4'd0, 1'b0, 2'd0, 32'h0);

    // Asynchronous reset in the middle of a fill
    start_fill(20'h55555, 2'd0, 20'hABCDE, 1'b0);
    fill_words(7, 32'h500, 0);
    #3;
    nrst = 1'b0;
    #1;
    last_rd = '0;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_victim_tag", victim_tag, 20'h0);
    check("mid_rst_rd_data", rd_data, 32'h0);
    check("mid_rst_wb_data", wb_data, 32'h0);
    check("mid_rst_hit", hit, 1'b0);
    #2;
    nrst = 1'b1;
    step();
    fill_line(20'h66666, 32'h600, 2'd0, 20'h0, 1'b0);
    lookup(20'h66666, 4'd0, 1'b1, 2'd0, 32'h600);
    lookup(20'h66666, 4'd7, 1'b1, 2'd0, 32'h607);
    lookup(20'h66666, 4'd15, 1'b1, 2'd0, 32'h60F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_set.md
Name: cache_set

Overview:
- Parametrised successor to the single-line cache storage: one set of WAYS lines, each LINE_WORDS words, with per-way tag/valid/dirty state.
- Adds parallel tag compare, hit-way select, replacement-victim choice, sequential line refill and victim read-out for writeback.
- Sits between the cache controller FSM and the memory/bus side. It is instantiated once per set index, or time-shared by the controller.

Parameters:
- WAYS, 4, number of ways; power of two, 1..8.
- OFFSET_WIDTH, 4, word-offset bits; LINE_WORDS = 2**OFFSET_WIDTH.
- TAG_WIDTH, 20, tag bits.

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- lk_req  in  1  lookup/read request.
- lk_tag  in  TAG_WIDTH  lookup tag.
- lk_off  in  OFFSET_WIDTH  lookup word offset.
- hit  out  1  combinational hit for lk_tag (valid way, tag equal, not filling).
- hit_way  out  log2(WAYS) (min 1)  index of the hitting way.
- rd_data  out  32  registered read word.
- rd_vld  out  1  pulses the cycle after a lk_req hit.
- st_req  in  1  store request; uses lk_tag/lk_off for addressing.
- st_data  in  32  store data.
- st_be  in  4  store byte enables.
- fill_start  in  1  begin refill of a victim with fill_tag.
- fill_tag  in  TAG_WIDTH  tag of the incoming line.
- fill_wr  in  1  one refill word present.
- fill_data  in  32  refill word.
- victim_way  out  log2(WAYS)  way chosen at fill_start.
- victim_tag  out  TAG_WIDTH  tag of the victim before fill_start.
- victim_dirty  out  1  victim was valid and dirty.
- wb_off  in  OFFSET_WIDTH  victim word select for writeback.
- wb_data  out  32  registered victim word.
- busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse after the last fill word.
- inv_all  in  1  invalidate every way.

Behaviour:
- Reset: all valid/dirty = 0, tags = 0, data = 0. Replacement state = 0, fill counter = 0. All outputs are 0 on reset.
- Lookup:
  - hit and hit_way are combinational.
  - On lk_req and hit, rd_data <= word at lk_off of hit_way; rd_vld = 1 next cycle. Replacement state is updated: hit_way becomes most recent.
  - On a miss, rd_vld = 0 and rd_data holds its previous value.
- Store:
  - On st_req and hit, the enabled bytes are written, the way's dirty bit is set, and replacement state is updated.
  - On st_req and miss, the store is ignored; the controller handles misses.
  - st_req and lk_req in the same cycle: both are serviced. rd_data returns the pre-store word.
- Victim selection at fill_start:
  - The lowest-index invalid way is chosen.
  - If no way is invalid, the replacement policy chooses the way.
  - victim_way, victim_tag and victim_dirty are registered and held until the next fill_start.
- Fill:
  - fill_start clears the victim's valid bit, latches fill_tag, zeroes the word counter and sets busy.
  - Each fill_wr writes fill_data at the counter offset, then increments the counter.
  - On the word with counter = LINE_WORDS-1: tag written, valid = 1, dirty = 0, busy = 0, fill_done pulses next cycle. The counter wraps to 0.
  - fill_wr while not busy is ignored. fill_start while busy is ignored.
  - Lookups to the filling way miss. Other ways remain fully usable during a fill.
  - The filled way becomes most recent on completion.
- Writeback: wb_data <= word at wb_off of victim_way every cycle, 1-cycle latency. It is valid until the first fill_wr overwrites that word, so the controller drains the victim before filling.
- inv_all clears all valid and dirty bits next edge and aborts any fill (busy = 0, no fill_done). Dirty data is discarded.
- Priority in one cycle: inv_all > fill_start > fill_wr; lk_req/st_req are independent.
- Reset asserted mid-fill: immediate return to reset state.

Optional Feature:
- CACHE_SET_PLRU_EN defined: tree pseudo-LRU, WAYS-1 bits. Access or fill flips the tree nodes on the path away from the touched way; the victim is found by following the node bits.
- Undefined: round-robin pointer of log2(WAYS) bits. It increments on each fill_start that selects a valid victim, and hits do not change it.
- Both variants use the invalid-way-first rule. WAYS = 1 always yields way 0.

Decomposition:
- Shared package cache_pkg: byte-enable width, word width (32), and a way-index width function clog2. Share it with the cache controller.
- One sub-module: cache_set_repl. It takes touch/touch_way/choose and returns victim_way, and holds the PLRU/round-robin state under the macro.
- Per-way storage stays inline as arrays.

Test Plan:
- Reset, then lk_req tag 0x12345 off 3 -> hit = 0, rd_vld = 0; busy = 0, victim_dirty = 0.
- fill_start tag 0xABCDE, then 16 fill_wr of data 0x100+i -> victim_way = 0, fill_done one cycle after the 16th word. lk_req 0xABCDE off 5 -> hit = 1, hit_way = 0, next cycle rd_data = 0x105.
- st_req hit off 2, st_data 0xDEADBEEF, st_be 4'b0011 -> next read of off 2 = 0x0000BEEF, ways' dirty set. The next fill that evicts this way gives victim_dirty = 1, victim_tag = 0xABCDE, wb_off 2 -> wb_data 0x0000BEEF.
- Fill ways 0..3, hit way 0 and way 2, then fill_start:
  - PLRU: victim_way = 1 or 3, per the tree.
  - Round-robin: victim_way = 0.
- During a fill of way 1, lookup of way 1's old tag -> miss; lookup of way 0 -> hit. inv_all mid-fill -> busy = 0, no fill_done, all subsequent lookups miss.
- Assert nrst low mid-fill (word 7) -> all outputs 0 asynchronously. After release, the fill counter restarts at 0 on the next fill_start.
